pt_dec: RTL
===========

PT_DEC -- requirements
Module: pt_dec

Interface
REQ-001 SHALL have parameter SHORT_MAX, default 7: a high pulse of 2..SHORT_MAX clk is short; a high pulse of SHORT_MAX+1..HIGH_MAX clk is long.
REQ-002 SHALL have parameter HIGH_MAX, default 20: the longest legal high pulse, in clk.
REQ-003 SHALL have parameter LOW_MAX, default 20: the longest legal intra-frame low gap, in clk.
REQ-004 SHALL have parameter SYNC_GAP, default 64: the low duration, in clk, that terminates a frame.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle low.
REQ-008 SHALL have port ad, output, 24 bits: decoded address/data, 2 bits per code bit, MSB code bit first.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse; ad is updated on that cycle.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse marking a malformed frame.

Function
REQ-011 SHALL pass rxd through a 2-flop synchroniser and use only the synchronised rxd_s internally.
REQ-012 SHALL use FSM states IDLE, HIGH, LOW, DISCARD; IDLE->HIGH on a rising edge of rxd_s.
REQ-013 In HIGH, SHALL count the clk cycles rxd_s is high with a saturating 8-bit counter.
REQ-014 On a falling edge, SHALL classify the pulse: width <2 or >HIGH_MAX -> err; short -> 0; long -> 1.
REQ-015 On a classified falling edge, SHALL shift the class bit into a 25-bit history and increment a pulse count that saturates at 26; the FSM then goes HIGH->LOW.
REQ-016 When the high counter exceeds HIGH_MAX while rxd_s is still high, SHALL pulse err and go to DISCARD without waiting for the falling edge.
REQ-017 In LOW, SHALL count the low cycles; a rising edge after 1..LOW_MAX cycles SHALL go LOW->HIGH.
REQ-018 A rising edge in LOW after LOW_MAX+1..SYNC_GAP-1 cycles SHALL pulse err and go to DISCARD.
REQ-019 When the low count reaches SYNC_GAP, frame end: if pulse count==25 and the last pulse was short, SHALL decode; otherwise SHALL pulse err; the FSM then returns to IDLE.
REQ-020 Decode SHALL map the first 24 pulses, pairwise in arrival order: short,short -> 2'b00 (zero); long,long -> 2'b01 (one); short,long -> 2'b10 (floating).
REQ-021 A long,short pair SHALL cause err, no valid, and ad unchanged.
REQ-022 On a good decode, SHALL register ad and assert valid the cycle after the low count reaches SYNC_GAP.
REQ-023 valid and err SHALL never assert on the same cycle, and each frame SHALL produce at most one of them.
REQ-024 A pulse count exceeding 25 SHALL cause err at frame end, not earlier.
REQ-025 In DISCARD, SHALL ignore all edges, clear the pulse count, and return to IDLE after SYNC_GAP consecutive low cycles, with no further err.
REQ-026 A sync gap arriving in IDLE or LOW with pulse count 0 SHALL produce neither valid nor err.
REQ-027 ad SHALL hold its value until the next valid.
REQ-028 Worst-case latency from the rxd falling edge of the sync pulse to valid SHALL be SYNC_GAP+3 clk.

Reset
REQ-029 While rst is high, SHALL set the FSM to IDLE, clear all counters and the history, set ad to 0, set valid and err to 0, and set both synchroniser flops to 0.
REQ-030 Assertion of rst mid-frame SHALL discard the partial frame silently, with no err.
REQ-031 After rst release, a rising edge on rxd_s SHALL be honoured starting on the first cycle.

Structure
REQ-032 Package pt_pkg SHALL hold CB_ZERO=2'b00, CB_ONE=2'b01, CB_HIZ=2'b10, the default timing constants, and the FSM state enum.
REQ-033 Sub-module pt_pulse_meas SHALL contain the synchroniser, the edge detect, and the high/low width counters, and SHALL output a classified pulse strobe, a sync strobe, a glitch strobe, and a timeout strobe.
REQ-034 pt_dec SHALL contain the FSM, the history register, the pair decode, and the output registers.

Verification
REQ-035 An encoder-timed frame for ad=24'h186186 (4/12-clk highs, 32-clk bits, 4-clk sync pulse + 124 low) -> one valid, ad=24'h186186, err=0.
REQ-036 Two back-to-back frames, 24'hFFFFFF-pattern (all 2'b01, i.e. 24'h555555) then 24'hAAAAAA -> two valids, with ad=24'h555555 then 24'hAAAAAA.
REQ-037 A frame whose code bit 5 is long-then-short -> err pulse, no valid, ad retains its prior value.
REQ-038 A frame truncated after 20 pulses, followed by 128 low -> err, no valid; a following good frame -> valid.
REQ-039 A 1-clk glitch mid-frame, or a 30-clk high -> err, then DISCARD; a subsequent good frame decodes correctly.
REQ-040 rst asserted at pulse 10 and released, then a good frame -> no err; valid with the correct ad.

Source files
------------

// File: rtl/pt_pkg.sv
// Shared constants, FSM states and pair decode for the pulse-train decoder.
// Latency: n/a (package only).
// Backpressure: n/a; the decoder output is a fire-and-forget strobe.
package pt_pkg;

  // Two-bit code values reported per decoded code bit
  localparam logic [1:0] CB_ZERO = 2'b00;
  localparam logic [1:0] CB_ONE  = 2'b01;
  localparam logic [1:0] CB_HIZ  = 2'b10;

  // Default timing, in clk cycles
  localparam int SHORT_MAX_DEF = 7;
  localparam int HIGH_MAX_DEF  = 20;
  localparam int LOW_MAX_DEF   = 20;
  localparam int SYNC_GAP_DEF  = 64;

  // 24 data pulses plus the trailing short sync pulse
  localparam logic [4:0] FRAME_PULSES = 5'd25;
  localparam logic [4:0] PCNT_SAT     = 5'd26;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DISCARD
  } state_t;

  typedef struct packed {
    logic [23:0] ad;
    logic        ok;
  } decode_t;

  // Pulses are 0=short, 1=long, earliest pulse in bit 23. Each arrival-order
  // pair becomes one code bit; long-then-short has no meaning and clears ok.
  function automatic decode_t pair_decode(input logic [23:0] p);
    decode_t    r;
    logic [1:0] pr;
    r.ad = '0;
    r.ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pr = p[23-2*i -: 2];
      case (pr)
        2'b00:   r.ad[23-2*i -: 2] = CB_ZERO;
        2'b11:   r.ad[23-2*i -: 2] = CB_ONE;
        2'b01:   r.ad[23-2*i -: 2] = CB_HIZ;
        default: begin
          r.ad[23-2*i -: 2] = CB_ZERO;
          r.ok = 1'b0;
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/pt_pulse_meas.sv
// Synchronises rxd, detects edges and measures high/low widths as strobes.
// Latency: 2 clk synchroniser, strobes are combinational off the width counters.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module pt_pulse_meas
  import pt_pkg::*;
#(
  parameter int SHORT_MAX = SHORT_MAX_DEF,
  parameter int HIGH_MAX  = HIGH_MAX_DEF,
  parameter int LOW_MAX   = LOW_MAX_DEF,
  parameter int SYNC_GAP  = SYNC_GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic pulse_stb,
  output logic pulse_long,
  output logic glitch_stb,
  output logic timeout_stb,
  output logic rise_stb,
  output logic gap_bad,
  output logic sync_stb
);

  localparam logic [7:0] SMAX  = 8'(SHORT_MAX);
  localparam logic [7:0] HMAX  = 8'(HIGH_MAX);
  localparam logic [7:0] HMAX1 = 8'(HIGH_MAX + 1);
  localparam logic [7:0] LMAX  = 8'(LOW_MAX);
  localparam logic [7:0] SGAP  = 8'(SYNC_GAP);

  logic       sync_q1;
  logic       rxd_s;
  logic       rxd_d;
  logic [7:0] hcnt;
  logic [7:0] lcnt;
  logic       rise;
  logic       fall;
  logic       width_ok;

  assign rise = rxd_s & ~rxd_d;
  assign fall = ~rxd_s & rxd_d;

  // Synchroniser, edge history and saturating run-length counters; on an
  // edge cycle the opposite counter still holds the finished run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      rxd_s   <= 1'b0;
      rxd_d   <= 1'b0;
      hcnt    <= '0;
      lcnt    <= '0;
    end else begin
      sync_q1 <= rxd;
      rxd_s   <= sync_q1;
      rxd_d   <= rxd_s;
      if (rxd_s) begin
        hcnt <= rise ? 8'd1 : ((hcnt == 8'hFF) ? hcnt : hcnt + 8'd1);
        lcnt <= '0;
      end else begin
        lcnt <= fall ? 8'd1 : ((lcnt == 8'hFF) ? lcnt : lcnt + 8'd1);
        hcnt <= '0;
      end
    end
  end

  // Classify finished runs and flag over-long ones while still in progress
  always_comb begin
    width_ok    = (hcnt >= 8'd2) && (hcnt <= HMAX);
    pulse_stb   = fall & width_ok;
    pulse_long  = hcnt > SMAX;
    glitch_stb  = fall & ~width_ok;
    timeout_stb = rxd_s & (hcnt == HMAX1);
    rise_stb    = rise;
    gap_bad     = lcnt > LMAX;
    sync_stb    = ~rxd_s & (lcnt == SGAP);
  end

endmodule

// File: rtl/pt_dec.sv
// Pulse-train frame decoder: 24 data pulses + short sync pulse -> 12 code bits.
// Latency: valid/err one clk after the sync gap completes (SYNC_GAP+3 from line).
// Backpressure: none; valid and err are one-cycle pulses, ad holds until next valid.
module pt_dec
  import pt_pkg::*;
#(
  parameter int SHORT_MAX = SHORT_MAX_DEF,
  parameter int HIGH_MAX  = HIGH_MAX_DEF,
  parameter int LOW_MAX   = LOW_MAX_DEF,
  parameter int SYNC_GAP  = SYNC_GAP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [23:0] ad,
  output logic        valid,
  output logic        err
);

  logic        pulse_stb;
  logic        pulse_long;
  logic        glitch_stb;
  logic        timeout_stb;
  logic        rise_stb;
  logic        gap_bad;
  logic        sync_stb;

  state_t      state;
  state_t      nxt;
  logic [4:0]  pcnt;
  logic [24:0] hist;
  decode_t     dec;
  logic        frame_end;
  logic        good;
  logic        err_set;
  logic        shift_en;
  logic        clr_cnt;

  pt_pulse_meas #(
    .SHORT_MAX (SHORT_MAX),
    .HIGH_MAX  (HIGH_MAX),
    .LOW_MAX   (LOW_MAX),
    .SYNC_GAP  (SYNC_GAP)
  ) u_meas (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .pulse_stb   (pulse_stb),
    .pulse_long  (pulse_long),
    .glitch_stb  (glitch_stb),
    .timeout_stb (timeout_stb),
    .rise_stb    (rise_stb),
    .gap_bad     (gap_bad),
    .sync_stb    (sync_stb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state: any malformation parks in DISCARD until a clean sync gap
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rise_stb) nxt = HIGH;
      HIGH:    if (timeout_stb || glitch_stb) nxt = DISCARD;
               else if (pulse_stb)            nxt = LOW;
      LOW:     if (rise_stb)                  nxt = gap_bad ? DISCARD : HIGH;
               else if (sync_stb)             nxt = IDLE;
      DISCARD: if (sync_stb) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Per-cycle actions; the frame verdict is taken only at the sync gap
  always_comb begin
    dec       = pair_decode(hist[24:1]);
    frame_end = (state == LOW) && sync_stb;
    good      = frame_end && (pcnt == FRAME_PULSES) && !hist[0] && dec.ok;
    err_set   = ((state == HIGH) && (timeout_stb || glitch_stb)) ||
                ((state == LOW) && rise_stb && gap_bad) ||
                (frame_end && (pcnt != 5'd0) && !good);
    shift_en  = (state == HIGH) && pulse_stb;
    clr_cnt   = frame_end || (state == DISCARD);
  end

  // History, pulse count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      hist  <= '0;
      ad    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (shift_en) begin
        hist <= {hist[23:0], pulse_long};
        if (pcnt != PCNT_SAT) pcnt <= pcnt + 5'd1;
      end else if (clr_cnt) begin
        pcnt <= '0;
      end
      valid <= good;
      err   <= err_set;
      if (good) ad <= dec.ad;
    end
  end

endmodule
